// File: rtl/reg_bank_write_arbiter.sv
//------------------------------------------------------------------------------
// reg_bank_write_arbiter
//
// Write-port arbiter and sequencer for the 4-unit data register bank of the
// Distributed Brain fabric. Four neuron units compete for the single addressed
// write port of the bank. They are served round-robin so that none starves.
// The layer sequencer can request a broadcast (writeAll) cycle, which takes
// priority over every unit write. The block also records which units have
// written since the last broadcast.
//
// Every output is registered. A request sampled at edge E produces its ack and
// bank command during the cycle E..E+1, and the bank captures it at edge E+1.
//
// Parameters
//   DATA_W   width of a data word; must match the bank
//   N_UNITS  number of requesting units; fixed at 4 because bank_addr is 2 bits
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous, active-low reset
//   req           per-unit write request; level, held until ack
//   req_data0..3  per-unit write data; stable while the matching req is high
//   ack           one-cycle grant pulse per unit
//   sync_req      broadcast request from the layer sequencer; level, held
//                 until sync_ack
//   sync_ack      one-cycle pulse marking the cycle the broadcast is issued
//   bank_data     to bank dataIn
//   bank_addr     to bank address
//   bank_wr_addr  to bank writeAddress
//   bank_wr_all   to bank writeAll
//   written       bit i set once unit i has written since the last
//                 broadcast or reset
//   all_written   high when all four units have written
//   busy          high when the bank sees any write command this cycle
//------------------------------------------------------------------------------
module reg_bank_write_arbiter #(
   parameter int DATA_W  = 32,
   parameter int N_UNITS = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_UNITS-1:0] req,
   input  logic [DATA_W-1:0]  req_data0,
   input  logic [DATA_W-1:0]  req_data1,
   input  logic [DATA_W-1:0]  req_data2,
   input  logic [DATA_W-1:0]  req_data3,
   output logic [N_UNITS-1:0] ack,
   input  logic               sync_req,
   output logic               sync_ack,
   output logic [DATA_W-1:0]  bank_data,
   output logic [1:0]         bank_addr,
   output logic               bank_wr_addr,
   output logic               bank_wr_all,
   output logic [N_UNITS-1:0] written,
   output logic               all_written,
   output logic               busy
);

   // The state is the bank command being presented during the current cycle.
   // It is one-hot, so each command strobe is a direct decode of one flop.
   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      WRITE = 3'b010,
      SYNC  = 3'b100
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [1:0]          rr_ptr;
   logic [N_UNITS-1:0]  eligible;
   logic                grant_found;
   logic [1:0]          grant_idx;
   logic [1:0]          cand;
   logic [N_UNITS-1:0]  grant_onehot;
   logic [DATA_W-1:0]   grant_data;
   logic                sync_pending;

   // A unit whose ack is out this cycle is masked from arbitration. The
   // requester only reacts to ack at the next edge, so its req may still be
   // high here. Without the mask it would be granted a second time for the
   // same request. The broadcast request is masked the same way.
   always_comb begin
      eligible     = req & ~ack;
      sync_pending = sync_req & ~sync_ack;
   end

   // Round-robin search. It starts at rr_ptr and walks upward modulo 4. The
   // first eligible unit found wins. rr_ptr always points just past the most
   // recent winner, so that winner is searched last on the next round.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = rr_ptr;
      cand        = rr_ptr;
      for (int k = 0; k < N_UNITS; k++) begin
         cand = rr_ptr + 2'(k);
         if (!grant_found && eligible[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   // Decode the winning index into the ack / written bit pattern.
   always_comb begin
      grant_onehot            = '0;
      grant_onehot[grant_idx] = 1'b1;
   end

   // Select the winning unit's data word for the bank data register.
   always_comb begin
      grant_data = req_data0;
      case (grant_idx)
         2'd0:    grant_data = req_data0;
         2'd1:    grant_data = req_data1;
         2'd2:    grant_data = req_data2;
         2'd3:    grant_data = req_data3;
         default: grant_data = req_data0;
      endcase
   end

   // Next-command selection runs every cycle and nothing is carried over. A
   // pending broadcast beats every unit. Otherwise any eligible unit gets a
   // WRITE, and with nothing to do the port goes IDLE.
   always_comb begin
      state_next = IDLE;
      if (sync_pending) begin
         state_next = SYNC;
      end else if (grant_found) begin
         state_next = WRITE;
      end
   end

   // State register. The asynchronous reset clears the command at once, so a
   // WRITE or SYNC cut short by reset never reaches the bank at the next edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Registered outputs and bookkeeping. ack and sync_ack are pulses, so they
   // are cleared every cycle unless this cycle's decision sets them. During a
   // broadcast, bank_data and bank_addr keep their old values. The bank
   // ignores them under writeAll, and holding them avoids needless toggling.
   // rr_ptr is also left alone during a broadcast, so the next unit in line
   // keeps its turn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack       <= '0;
         sync_ack  <= 1'b0;
         bank_data <= '0;
         bank_addr <= 2'd0;
         written   <= '0;
         rr_ptr    <= 2'd0;
      end else begin
         ack      <= '0;
         sync_ack <= 1'b0;
         case (state_next)
            WRITE: begin
               ack       <= grant_onehot;
               bank_addr <= grant_idx;
               bank_data <= grant_data;
               written   <= written | grant_onehot;
               rr_ptr    <= grant_idx + 2'd1;
            end
            SYNC: begin
               sync_ack <= 1'b1;
               written  <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   // The command strobes decode the one-hot state flops directly, so they
   // stay registered. Only one state bit can be set at a time, which means
   // writeAddress and writeAll can never be asserted together.
   assign bank_wr_addr = (state == WRITE);
   assign bank_wr_all  = (state == SYNC);
   assign all_written  = &written;
   assign busy         = bank_wr_addr | bank_wr_all;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
`timescale 1ns/1ps
module tb_reg_bank_write_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] req_data0, req_data1, req_data2, req_data3;
   logic [3:0]  ack;
   logic        sync_req;
   logic        sync_ack;
   logic [31:0] bank_data;
   logic [1:0]  bank_addr;
   logic        bank_wr_addr;
   logic        bank_wr_all;
   logic [3:0]  written;
   logic        all_written;
   logic        busy;

   int errors = 0;
   int checks = 0;

   reg_bank_write_arbiter #(.DATA_W(32), .N_UNITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .req_data0(req_data0), .req_data1(req_data1),
      .req_data2(req_data2), .req_data3(req_data3),
      .ack(ack), .sync_req(sync_req), .sync_ack(sync_ack),
      .bank_data(bank_data), .bank_addr(bank_addr),
      .bank_wr_addr(bank_wr_addr), .bank_wr_all(bank_wr_all),
      .written(written), .all_written(all_written), .busy(busy)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge, then move 1 ns past it so outputs are sampled
   // and inputs are driven well clear of the edge.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Put the design back into its reset state. Release happens away from any
   // clock edge.
   task automatic do_reset;
      req = 4'b0000;
      sync_req = 1'b0;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      req = 4'b0000;
      sync_req = 1'b0;
      req_data0 = 32'h0; req_data1 = 32'h0; req_data2 = 32'h0; req_data3 = 32'h0;
      rst_n = 1'b0;
      tick();
      tick();
      checks++;
      if (ack !== 4'b0000 || sync_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_ack: got ack=%b sync_ack=%b expected 0000/0", ack, sync_ack);
      end
      checks++;
      if (bank_data !== 32'h0 || bank_addr !== 2'd0) begin
         errors++;
         $display("[TB] FAIL reset_bank: got data=%h addr=%0d expected 0/0", bank_data, bank_addr);
      end
      checks++;
      if (bank_wr_addr !== 1'b0 || bank_wr_all !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_cmd: got wr_addr=%b wr_all=%b busy=%b expected 0/0/0",
                  bank_wr_addr, bank_wr_all, busy);
      end
      checks++;
      if (written !== 4'b0000 || all_written !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_written: got written=%b all=%b expected 0000/0", written, all_written);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_write;
      req_data2 = 32'hDEADBEEF;
      req = 4'b0100;
      tick();
      req = 4'b0000;
      checks++;
      if (ack !== 4'b0100 || bank_wr_addr !== 1'b1 || bank_wr_all !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_cmd: got ack=%b wr_addr=%b wr_all=%b expected 0100/1/0",
                  ack, bank_wr_addr, bank_wr_all);
      end
      checks++;
      if (bank_addr !== 2'd2 || bank_data !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL single_bank: got addr=%0d data=%h expected 2/deadbeef", bank_addr, bank_data);
      end
      checks++;
      if (written !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL single_written: got %b expected 0100", written);
      end
      tick();
      checks++;
      if (ack !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_idle: got ack=%b busy=%b expected 0000/0", ack, busy);
      end
      // rr_ptr is now 3, so with units 0 and 3 both asking, unit 3 goes first.
      req_data0 = 32'h0000_0A0A;
      req_data3 = 32'h0000_3A3A;
      req = 4'b1001;
      tick();
      req = 4'b0001;
      checks++;
      if (ack !== 4'b1000 || bank_addr !== 2'd3 || bank_data !== 32'h0000_3A3A) begin
         errors++;
         $display("[TB] FAIL single_rrptr: got ack=%b addr=%0d data=%h expected 1000/3/00003a3a",
                  ack, bank_addr, bank_data);
      end
      tick();
      req = 4'b0000;
      checks++;
      if (ack !== 4'b0001 || bank_addr !== 2'd0 || bank_data !== 32'h0000_0A0A) begin
         errors++;
         $display("[TB] FAIL single_rrnext: got ack=%b addr=%0d data=%h expected 0001/0/00000a0a",
                  ack, bank_addr, bank_data);
      end
      tick();
   endtask

   task automatic test_all_units;
      do_reset();
      req_data0 = 32'h1000_0000; req_data1 = 32'h1000_0001;
      req_data2 = 32'h1000_0002; req_data3 = 32'h1000_0003;
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         tick();
         req[i] = 1'b0;
         checks++;
         if (ack !== (4'b0001 << i) || bank_addr !== 2'(i) || bank_data !== (32'h1000_0000 + 32'(i))) begin
            errors++;
            $display("[TB] FAIL all_units_grant%0d: got ack=%b addr=%0d data=%h expected %b/%0d/%h",
                     i, ack, bank_addr, bank_data, 4'b0001 << i, i, 32'h1000_0000 + 32'(i));
         end
         checks++;
         if (busy !== 1'b1 || all_written !== (i == 3)) begin
            errors++;
            $display("[TB] FAIL all_units_busy%0d: got busy=%b all_written=%b expected 1/%b",
                     i, busy, all_written, (i == 3));
         end
      end
      tick();
      checks++;
      if (busy !== 1'b0 || ack !== 4'b0000 || written !== 4'b1111 || all_written !== 1'b1) begin
         errors++;
         $display("[TB] FAIL all_units_after: got busy=%b ack=%b written=%b all=%b expected 0/0000/1111/1",
                  busy, ack, written, all_written);
      end
   endtask

   // Units 0 and 1 keep requesting continuously with new data every cycle. The
   // grants have to alternate with no gap between them.
   task automatic test_back_to_back;
      logic [31:0] exp_data;
      req = 4'b0011;
      for (int c = 0; c < 6; c++) begin
         req_data0 = 32'hA000_0000 + 32'(c);
         req_data1 = 32'hB000_0000 + 32'(c);
         tick();
         exp_data = ((c % 2) == 0) ? (32'hA000_0000 + 32'(c)) : (32'hB000_0000 + 32'(c));
         checks++;
         if (ack !== (4'b0001 << (c % 2)) || bank_data !== exp_data || bank_wr_addr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL back_to_back_%0d: got ack=%b data=%h wr_addr=%b expected %b/%h/1",
                     c, ack, bank_data, bank_wr_addr, 4'b0001 << (c % 2), exp_data);
         end
      end
      req = 4'b0000;
      tick();
      checks++;
      if (written !== 4'b1111 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL back_to_back_end: got written=%b busy=%b expected 1111/0", written, busy);
      end
   endtask

   task automatic test_sync_preempt;
      req_data1 = 32'h5555_1111;
      sync_req = 1'b1;
      req = 4'b0010;
      tick();
      sync_req = 1'b0;
      checks++;
      if (bank_wr_all !== 1'b1 || sync_ack !== 1'b1 || bank_wr_addr !== 1'b0 || ack !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL sync_first: got wr_all=%b sync_ack=%b wr_addr=%b ack=%b expected 1/1/0/0000",
                  bank_wr_all, sync_ack, bank_wr_addr, ack);
      end
      checks++;
      if (written !== 4'b0000 || all_written !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sync_clear: got written=%b all=%b expected 0000/0", written, all_written);
      end
      checks++;
      if (bank_data !== 32'hB000_0005 || bank_addr !== 2'd1) begin
         errors++;
         $display("[TB] FAIL sync_hold: got data=%h addr=%0d expected b0000005/1", bank_data, bank_addr);
      end
      tick();
      req = 4'b0000;
      checks++;
      if (ack !== 4'b0010 || bank_wr_addr !== 1'b1 || bank_data !== 32'h5555_1111 || written !== 4'b0010) begin
         errors++;
         $display("[TB] FAIL sync_then_unit: got ack=%b wr_addr=%b data=%h written=%b expected 0010/1/55551111/0010",
                  ack, bank_wr_addr, bank_data, written);
      end
      tick();
   endtask

   // sync_req is held level alongside a held unit request. The broadcast is
   // masked on its ack cycle, so SYNC and WRITE alternate.
   task automatic test_sync_held;
      logic [3:0] exp_ack;
      logic       exp_all;
      req_data2 = 32'h2222_2222;
      sync_req = 1'b1;
      req = 4'b0100;
      for (int c = 0; c < 4; c++) begin
         tick();
         exp_all = ((c % 2) == 0);
         exp_ack = exp_all ? 4'b0000 : 4'b0100;
         checks++;
         if (bank_wr_all !== exp_all || sync_ack !== exp_all || bank_wr_addr !== !exp_all || ack !== exp_ack) begin
            errors++;
            $display("[TB] FAIL sync_held_%0d: got wr_all=%b sync_ack=%b wr_addr=%b ack=%b expected %b/%b/%b/%b",
                     c, bank_wr_all, sync_ack, bank_wr_addr, ack, exp_all, exp_all, !exp_all, exp_ack);
         end
      end
      sync_req = 1'b0;
      req = 4'b0000;
      tick();
   endtask

   task automatic test_reset_mid_write;
      req_data3 = 32'h3333_0003;
      req = 4'b1000;
      tick();
      checks++;
      if (ack !== 4'b1000 || bank_wr_addr !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_pre: got ack=%b wr_addr=%b expected 1000/1", ack, bank_wr_addr);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (ack !== 4'b0000 || bank_wr_addr !== 1'b0 || bank_wr_all !== 1'b0 || busy !== 1'b0 ||
          bank_data !== 32'h0 || bank_addr !== 2'd0 || written !== 4'b0000 || sync_ack !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_clear: got ack=%b wr_addr=%b wr_all=%b data=%h addr=%0d written=%b expected all zero",
                  ack, bank_wr_addr, bank_wr_all, bank_data, bank_addr, written);
      end
      #1 rst_n = 1'b1;
      tick();
      req = 4'b0000;
      checks++;
      if (ack !== 4'b1000 || bank_addr !== 2'd3 || bank_data !== 32'h3333_0003 || written !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL midrst_regrant: got ack=%b addr=%0d data=%h written=%b expected 1000/3/33330003/1000",
                  ack, bank_addr, bank_data, written);
      end
      tick();
   endtask

   // Random requesters and broadcasts, checked cycle by cycle against a
   // behavioural model of the arbiter. The model also checks the wait bound
   // for every request.
   task automatic test_random;
      logic [3:0]  m_ack, req_s, elig, e_ack, e_written;
      logic        m_sync_ack, sync_s, e_all, e_addr_wr;
      logic [1:0]  m_rr, e_addr;
      logic [31:0] e_data;
      logic [31:0] data_s [4];
      int          wait_cnt [4];
      int          g;
      do_reset();
      m_ack = 4'b0; m_sync_ack = 1'b0; m_rr = 2'd0;
      e_written = 4'b0; e_addr = 2'd0; e_data = 32'h0;
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         req_s = req; sync_s = sync_req;
         data_s[0] = req_data0; data_s[1] = req_data1;
         data_s[2] = req_data2; data_s[3] = req_data3;
         tick();
         elig = req_s & ~m_ack;
         e_ack = 4'b0; e_all = 1'b0; e_addr_wr = 1'b0;
         if (sync_s && !m_sync_ack) begin
            e_all = 1'b1;
            e_written = 4'b0;
         end else if (elig != 4'b0) begin
            g = -1;
            for (int k = 0; k < 4; k++) begin
               if (g < 0 && elig[(int'(m_rr) + k) % 4]) g = (int'(m_rr) + k) % 4;
            end
            e_addr_wr = 1'b1;
            e_ack[g] = 1'b1;
            e_addr = 2'(g);
            e_data = data_s[g];
            e_written[g] = 1'b1;
            m_rr = 2'((g + 1) % 4);
         end
         m_ack = e_ack;
         m_sync_ack = e_all;
         checks++;
         if (bank_wr_addr === 1'b1 && bank_wr_all === 1'b1) begin
            errors++;
            $display("[TB] FAIL rand_exclusive cycle %0d: got wr_addr=1 wr_all=1 expected not both", cyc);
         end
         checks++;
         if (ack !== e_ack || bank_wr_addr !== e_addr_wr || bank_wr_all !== e_all || sync_ack !== e_all) begin
            errors++;
            $display("[TB] FAIL rand_cmd cycle %0d: got ack=%b wr_addr=%b wr_all=%b sync_ack=%b expected %b/%b/%b/%b",
                     cyc, ack, bank_wr_addr, bank_wr_all, sync_ack, e_ack, e_addr_wr, e_all, e_all);
         end
         checks++;
         if (bank_addr !== e_addr || bank_data !== e_data || written !== e_written) begin
            errors++;
            $display("[TB] FAIL rand_bank cycle %0d: got addr=%0d data=%h written=%b expected %0d/%h/%b",
                     cyc, bank_addr, bank_data, written, e_addr, e_data, e_written);
         end
         for (int i = 0; i < 4; i++) begin
            if (e_ack[i]) wait_cnt[i] = 0;
            else if (req_s[i] && !e_all) wait_cnt[i]++;
         end
         checks++;
         if (wait_cnt[0] >= 5 || wait_cnt[1] >= 5 || wait_cnt[2] >= 5 || wait_cnt[3] >= 5) begin
            errors++;
            $display("[TB] FAIL rand_latency cycle %0d: got waits %0d %0d %0d %0d expected each below 5",
                     cyc, wait_cnt[0], wait_cnt[1], wait_cnt[2], wait_cnt[3]);
            for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
         end
         // Requesters drop on seeing their ack and may raise a new request
         // with fresh data. The sequencer drops sync_req on seeing sync_ack.
         for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
               req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 3) == 0) begin
               case (i)
                  0: req_data0 = $urandom;
                  1: req_data1 = $urandom;
                  2: req_data2 = $urandom;
                  default: req_data3 = $urandom;
               endcase
               req[i] = 1'b1;
            end
         end
         if (sync_ack) sync_req = 1'b0;
         else if (!sync_req && $urandom_range(0, 15) == 0) sync_req = 1'b1;
      end
      req = 4'b0000;
      sync_req = 1'b0;
      tick();
   endtask

   initial begin
      rst_n = 1'b0;
      req = 4'b0000;
      sync_req = 1'b0;
      req_data0 = 32'h0; req_data1 = 32'h0; req_data2 = 32'h0; req_data3 = 32'h0;
      test_reset();
      test_single_write();
      test_all_units();
      test_back_to_back();
      test_sync_preempt();
      test_sync_held();
      test_reset_mid_write();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
